// File: rtl/nand_bus_pkg.sv
// Shared types and default timing for the NAND bus CE arbiter.
package nand_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OWN,
    HOLD,
    GAP
  } arb_state_t;

  localparam int NUM_TGT_DEFAULT = 8;
  localparam int T_SETUP_DEFAULT = 2;
  localparam int T_HOLD_DEFAULT  = 2;
  localparam int T_GAP_DEFAULT   = 1;
  localparam int CNT_W_DEFAULT   = 4;

  // Index width for a target count; a single target still needs one bit.
  function automatic int tgt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nand_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above rr_ptr, wrapping to 0.
module nand_rr_pick #(
  parameter int NUM_TGT = 8,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_TGT-1:0] elig,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               any
);

  localparam logic [PTR_W:0] NUM_W = (PTR_W + 1)'(NUM_TGT);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sel = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (sum >= NUM_W) sum = sum - NUM_W;
      idx = sum[PTR_W-1:0];
      if (!any && elig[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/nand_bus_ce_arbiter.sv
// Round-robin chip-enable arbiter sharing one ONFI NAND bus between NUM_TGT targets.
// Optional ownership watchdog is enabled by defining NAND_ARB_WDOG_EN.
module nand_bus_ce_arbiter
  import nand_bus_pkg::*;
#(
  parameter int NUM_TGT = NUM_TGT_DEFAULT,
  parameter int T_SETUP = T_SETUP_DEFAULT,
  parameter int T_HOLD  = T_HOLD_DEFAULT,
  parameter int T_GAP   = T_GAP_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
`ifdef NAND_ARB_WDOG_EN
  ,
  parameter int MAX_HOLD = 4096
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_TGT-1:0]          req,
  input  logic                        rel,
  input  logic [NUM_TGT-1:0]          rb_n,
  output logic [NUM_TGT-1:0]          gnt,
  output logic [NUM_TGT-1:0]          cen,
  output logic [tgt_w(NUM_TGT)-1:0]   cur_tgt,
  output logic                        bus_busy,
  output logic [NUM_TGT-1:0]          rb_sync,
  output logic                        wdog_err
);

  localparam int TGT_W = tgt_w(NUM_TGT);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((T_GAP > 0) ? T_GAP - 1 : 0);
  localparam logic [TGT_W-1:0] LAST_TGT   = TGT_W'(NUM_TGT - 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TGT_W-1:0]   sel_q, sel_d;
  logic [TGT_W-1:0]   rr_q, rr_d;
  logic [NUM_TGT-1:0] cen_d, gnt_d;
  logic               busy_d;

  logic [NUM_TGT-1:0] rb_meta;
  logic [NUM_TGT-1:0] elig;
  logic [TGT_W-1:0]   pick_sel;
  logic               pick_any;

  // rb_n is asynchronous to clk; two flops per bit, reset to "busy".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_meta <= '0;
      rb_sync <= '0;
    end else begin
      rb_meta <= rb_n;
      rb_sync <= rb_meta;
    end
  end

  assign elig = req & rb_sync;

  nand_rr_pick #(
    .NUM_TGT (NUM_TGT),
    .PTR_W   (TGT_W)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_q),
    .sel    (pick_sel),
    .any    (pick_any)
  );

`ifdef NAND_ARB_WDOG_EN
  localparam int WD_W = $clog2(MAX_HOLD + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      rr_q     <= '0;
      cen      <= '1;
      gnt      <= '0;
      bus_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      cen      <= cen_d;
      gnt      <= gnt_d;
      bus_busy <= busy_d;
    end
  end

`ifdef NAND_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign wdog_err = err_q;
`else
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
`ifdef NAND_ARB_WDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          sel_d   = pick_sel;
          rr_d    = (pick_sel == LAST_TGT) ? '0 : pick_sel + TGT_W'(1);
        end
      end
      SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (req[sel_q]) begin
          state_d = OWN;
`ifdef NAND_ARB_WDOG_EN
          wd_d    = '0;
`endif
        end else begin
          // Requester withdrew during setup: close out CE timing without a grant.
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      OWN: begin
        if (rel) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
`ifdef NAND_ARB_WDOG_EN
        else if (wd_q == WD_W'(MAX_HOLD - 1)) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (T_GAP > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so cen/gnt come straight off flops.
  always_comb begin
    cen_d  = '1;
    gnt_d  = '0;
    busy_d = 1'b0;
    case (state_d)
      SETUP, HOLD: begin
        cen_d[sel_d] = 1'b0;
        busy_d       = 1'b1;
      end
      OWN: begin
        cen_d[sel_d] = 1'b0;
        gnt_d[sel_d] = 1'b1;
        busy_d       = 1'b1;
      end
      default: ;
    endcase
  end

  assign cur_tgt = sel_q;

endmodule

// File: tb/tb_nand_bus_ce_arbiter.sv
// Self-checking bench for nand_bus_ce_arbiter: timestamp-based reference model plus directed scenarios.
module tb_nand_bus_ce_arbiter;

  localparam int N  = 8;
  localparam int TS = 2;
  localparam int TH = 2;
  localparam int TG = 1;
`ifdef NAND_ARB_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
  localparam int MAXH    = 16;
`else
  localparam bit WDOG_ON = 1'b0;
  localparam int MAXH    = 1 << 30;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] rb_n;
  logic [N-1:0] gnt;
  logic [N-1:0] cen;
  logic [2:0]   cur_tgt;
  logic         bus_busy;
  logic [N-1:0] rb_sync;
  logic         wdog_err;

  nand_bus_ce_arbiter #(
    .NUM_TGT (N),
    .T_SETUP (TS),
    .T_HOLD  (TH),
    .T_GAP   (TG),
    .CNT_W   (4)
`ifdef NAND_ARB_WDOG_EN
    ,
    .MAX_HOLD(MAXH)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rel      (rel),
    .rb_n     (rb_n),
    .gnt      (gnt),
    .cen      (cen),
    .cur_tgt  (cur_tgt),
    .bus_busy (bus_busy),
    .rb_sync  (rb_sync),
    .wdog_err (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each ownership is a set of edge timestamps (decision, setup end,
  // release, CE-high) counted in clock edges; outputs follow from where "now" falls.
  int           m_cyc;
  int           m_owner, m_ptr;
  int           m_setup_end, m_gnt_from, m_rel_at, m_end, m_next_free;
  bit           m_busy, m_wdog;
  logic [N-1:0] m_meta, m_sync;

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_busy = 1'b0; m_wdog = 1'b0;
    m_setup_end = -1; m_gnt_from = -1; m_rel_at = -1; m_end = -1; m_next_free = 0;
    m_meta = '0; m_sync = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    int j;
    m_cyc++;
    elig   = req & m_sync;
    m_sync = m_meta;
    m_meta = rb_n;
    if (m_busy) begin
      if (m_cyc == m_setup_end) begin
        if (req[m_owner]) m_gnt_from = m_cyc;
        else              m_end = m_cyc + TH;
      end else if (m_gnt_from >= 0 && m_rel_at < 0 && m_cyc > m_gnt_from) begin
        if (rel) begin
          m_rel_at = m_cyc; m_end = m_cyc + TH;
        end else if (WDOG_ON && m_cyc == m_gnt_from + MAXH) begin
          m_rel_at = m_cyc; m_end = m_cyc + TH; m_wdog = 1'b1;
        end
      end
      if (m_cyc == m_end) begin
        m_busy = 1'b0;
        m_next_free = m_cyc + TG + 1;
      end
    end else if (m_cyc >= m_next_free && elig != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        j = (m_ptr + i) % N;
        if (elig[j]) m_owner = j;
      end
      m_ptr = (m_owner + 1) % N;
      m_busy = 1'b1;
      m_setup_end = m_cyc + TS;
      m_gnt_from = -1; m_rel_at = -1; m_end = -1;
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_cen, e_gnt;
    e_cen = '1;
    e_gnt = '0;
    if (m_busy) begin
      e_cen[m_owner] = 1'b0;
      if (m_gnt_from >= 0 && m_rel_at < 0) e_gnt[m_owner] = 1'b1;
    end
    check("cen", cen, e_cen);
    check("gnt", gnt, e_gnt);
    check("bus_busy", bus_busy, m_busy);
    check("rb_sync", rb_sync, m_sync);
    check("wdog_err", wdog_err, m_wdog);
    if (m_busy) check("cur_tgt", cur_tgt, m_owner);
    check("cen_onehot0", ($countones(~cen) <= 1), 1'b1);
    check("gnt_onehot0", $onehot0(gnt), 1'b1);
    check("gnt_implies_cen", ((gnt & cen) == '0), 1'b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_cen", cen, 8'hFF);
    check("rst_gnt", gnt, 8'h00);
    check("rst_busy", bus_busy, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_any_gnt(output int idx, input int budget);
    idx = -1;
    for (int i = 0; i < budget && idx < 0; i++) begin
      cycle();
      for (int b = 0; b < N; b++) if (gnt[b]) idx = b;
    end
    if (idx < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL gnt_timeout actual=none required=grant within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout actual=still running required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int idx, low, gap, own, r;
    bit gseen;
    m_cyc = 0;
    rst_n = 1'b1; req = '0; rel = 1'b0; rb_n = '1;
    model_reset();
    #1;
    apply_reset();

    // Single request: cen at +1, gnt at +1+T_SETUP, cen high T_HOLD after rel.
    repeat (3) cycle();
    req = 8'h01;
    cycle(); check("t1_cen_low", cen, 8'hFE); check("t1_no_gnt", gnt, 8'h00);
    cycle(); check("t1_setup", gnt, 8'h00);
    cycle(); check("t1_gnt", gnt, 8'h01);
    repeat (2) cycle();
    rel = 1'b1;
    cycle(); rel = 1'b0; req = '0;
    check("t1_gnt_drop", gnt, 8'h00); check("t1_hold", cen, 8'hFE);
    cycle(); check("t1_hold2", cen, 8'hFE);
    cycle(); check("t1_cen_high", cen, 8'hFF);

    // Busy target is never picked; ready takes 2 sync cycles plus the arbitration cycle.
    rb_n = 8'hFB;
    repeat (3) cycle();
    req = 8'h04;
    for (int i = 0; i < 5; i++) begin
      cycle(); check("t3_blocked", cen, 8'hFF);
    end
    rb_n = 8'hFF;
    cycle(); check("t3_sync1", cen, 8'hFF);
    cycle(); check("t3_sync2", cen, 8'hFF);
    cycle(); check("t3_cen_low", cen, 8'hFB);
    wait_any_gnt(idx, 10); check("t3_owner", idx, 2);
    req = '0; rel = 1'b1;
    cycle(); rel = 1'b0;
    repeat (5) cycle();

    // Request withdrawn during setup: no grant, CE low for T_SETUP+T_HOLD.
    req = 8'h08;
    cycle(); check("t4_cen_low", cen, 8'hF7);
    req = '0;
    low = 1; gseen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!cen[3]) low++;
      if (gnt != '0) gseen = 1'b1;
    end
    check("t4_low_cycles", low, TS + TH);
    check("t4_no_gnt", gseen, 1'b0);
    check("t4_idle", bus_busy, 1'b0);

    // Reset during OWN of target 5; afterwards the pointer restarts at target 0.
    req = 8'h20;
    wait_any_gnt(idx, 20); check("t5_owner", idx, 5);
    repeat (2) cycle();
    req = 8'h81;
    apply_reset();
    cycle(); check("t5_sync1", cen, 8'hFF);
    cycle(); check("t5_sync2", cen, 8'hFF);
    cycle(); check("t5_first_pick", cen, 8'hFE); check("t5_cur_tgt", cur_tgt, 0);

    // Two requesters alternate; between ownerships all CE are high for the GAP
    // cycles plus the IDLE decision cycle.
    for (int k = 0; k < 4; k++) begin
      wait_any_gnt(idx, 20);
      check("t2_order", idx, (k % 2 == 0) ? 0 : 7);
      repeat (4) cycle();
      if (k == 3) req = '0;
      rel = 1'b1;
      cycle(); rel = 1'b0;
      if (k < 3) begin
        cycle();
        gap = 0;
        for (int i = 0; i < 10; i++) begin
          cycle();
          if (cen == 8'hFF) gap++;
          else break;
        end
        check("t2_gap", gap, TG + 1);
      end
    end
    repeat (5) cycle();

`ifdef NAND_ARB_WDOG_EN
    // Owner never releases: watchdog ends OWN after MAX_HOLD cycles and latches the error.
    req = 8'h02;
    wait_any_gnt(idx, 20); check("t6_owner", idx, 1);
    own = 1;
    for (int i = 0; i < 40 && gnt[1]; i++) begin
      cycle();
      if (gnt[1]) own++;
    end
    check("t6_own_cycles", own, MAXH);
    check("t6_wdog", wdog_err, 1'b1);
    req = 8'h04;
    wait_any_gnt(idx, 20); check("t6_next", idx, 2);
    check("t6_sticky", wdog_err, 1'b1);
    req = '0; rel = 1'b1;
    cycle(); rel = 1'b0;
    repeat (5) cycle();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        r = $urandom_range(N - 1);
        req[r] = ~req[r];
      end
      if ($urandom_range(15) == 0) begin
        r = $urandom_range(N - 1);
        rb_n[r] = ~rb_n[r];
      end
      rel = ($urandom_range(4) == 0);
      cycle();
    end
    rel = 1'b0; req = '0; rb_n = '1;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
